// File: rtl/axi_pkg.sv
// Shared definitions for the AXI-lite read arbiter slice.
// Holds the FSM state encoding, response codes and default bus widths.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } axi_state_e;

    // Plain 2-bit constants for the state register, kept in step with the enum.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ADDR = ADDR;
    localparam logic [1:0] ST_DATA = DATA;
    localparam logic [1:0] ST_ERR  = ERR;

    localparam logic RESP_OKAY = 1'b0;
    localparam logic RESP_ERR  = 1'b1;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI-lite read channel bundle (address + read-data halves).
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both high; the source holds valid and its payload stable until then.
// Modports:
//   master - issues addresses, consumes data (drives araddr_*, raddr_ready)
//   slave  - accepts addresses, returns data (drives araddr_ready, raddr_*)
interface axi_rd_if
    import axi_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
);
    logic              araddr_valid;
    logic              araddr_ready;
    logic [ADDR_W-1:0] araddr_bits_addr;
    logic              raddr_valid;
    logic              raddr_ready;
    logic [DATA_W-1:0] raddr_bits_data;
    logic              raddr_bits_resp;

    modport master (
        output araddr_valid, araddr_bits_addr, raddr_ready,
        input  araddr_ready, raddr_valid, raddr_bits_data, raddr_bits_resp
    );

    modport slave (
        input  araddr_valid, araddr_bits_addr, raddr_ready,
        output araddr_ready, raddr_valid, raddr_bits_data, raddr_bits_resp
    );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin selector.
// Ports: req[1:0] request vector, last = index served most recently,
//        gnt_idx = chosen requester, gnt_valid = any request present.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_valid
);
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            // Tie: whoever was not served last goes next.
            gnt_idx = ~last;
        end else if (req[1]) begin
            gnt_idx = 1'b1;
        end
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI-lite read channel between the IFU (m0) and
// the LSU (m1). Round-robin grant, one transaction in flight, watchdog that
// completes a hung transaction with an error response.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   m0, m1          requester-facing channels (slave modport)
//   io_AXI          memory-facing channel (master modport)
//   busy            transaction in flight (state != IDLE)
//   timeout_err     sticky watchdog flag, cleared only by reset
//   dbg_state       current FSM state encoding
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int DATA_W  = AXI_DATA_W,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    axi_rd_if.slave     m0,
    axi_rd_if.slave     m1,
    axi_rd_if.master    io_AXI,
    output logic        busy,
    output logic        timeout_err,
    output logic [1:0]  dbg_state
);
    // Last counter value at which a transaction may still finish normally.
    localparam logic [CNT_W-1:0] TMO_LAST =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              terr_q, terr_d;

    logic              sel_idx, sel_valid, ar_ready, expired;
    logic [ADDR_W-1:0] sel_addr;
    logic              g_rready, g_rvalid, g_rresp;
    logic [DATA_W-1:0] g_rdata;
    logic              io_arvalid, io_rready;

    rr_arb2 u_arb (
        .req       ({m1.araddr_valid, m0.araddr_valid}),
        .last      (last_q),
        .gnt_idx   (sel_idx),
        .gnt_valid (sel_valid)
    );

    assign sel_addr = sel_idx ? m1.araddr_bits_addr : m0.araddr_bits_addr;
    assign g_rready = gnt_q ? m1.raddr_ready : m0.raddr_ready;
    // Gated by rst so that no ready is offered while reset is held.
    assign ar_ready = rst && (state_q == ST_IDLE) && sel_valid;
    // >= rather than == so a transaction that slips past the boundary in
    // ADDR (counter keeps running) is still caught in DATA.
    assign expired  = (TIMEOUT != 0) && (cnt_q >= TMO_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        g_rvalid   = 1'b0;
        g_rdata    = '0;
        g_rresp    = RESP_OKAY;
        io_arvalid = 1'b0;
        io_rready  = 1'b0;

        if ((state_q == ST_ADDR) || (state_q == ST_DATA)) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ar_ready) begin
                    addr_d  = sel_addr;
                    gnt_d   = sel_idx;
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                io_arvalid = 1'b1;
                if (io_AXI.araddr_ready) begin
                    state_d = ST_DATA;
                end else if (expired) begin
                    state_d = ST_ERR;
                    terr_d  = 1'b1;
                end
            end
            ST_DATA: begin
                g_rvalid  = io_AXI.raddr_valid;
                io_rready = g_rready;
                if (io_AXI.raddr_valid) begin
                    g_rdata = io_AXI.raddr_bits_data;
                    g_rresp = io_AXI.raddr_bits_resp;
                end
                if (io_AXI.raddr_valid && g_rready) begin
                    last_d  = gnt_q;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    state_d = ST_ERR;
                    terr_d  = 1'b1;
                end
            end
            default: begin // ST_ERR: synthesize an error beat, swallow late slave data
                g_rvalid  = 1'b1;
                g_rresp   = RESP_ERR;
                io_rready = 1'b1;
                if (g_rready) begin
                    last_d  = gnt_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign m0.araddr_ready    = ar_ready && !sel_idx;
    assign m1.araddr_ready    = ar_ready && sel_idx;
    assign m0.raddr_valid     = g_rvalid && !gnt_q;
    assign m1.raddr_valid     = g_rvalid && gnt_q;
    assign m0.raddr_bits_data = gnt_q ? '0 : g_rdata;
    assign m1.raddr_bits_data = gnt_q ? g_rdata : '0;
    assign m0.raddr_bits_resp = !gnt_q && g_rresp;
    assign m1.raddr_bits_resp = gnt_q && g_rresp;

    assign io_AXI.araddr_valid     = io_arvalid;
    assign io_AXI.araddr_bits_addr = (state_q == ST_ADDR) ? addr_q : '0;
    assign io_AXI.raddr_ready      = io_rready;

    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed stimulus, a transaction-level reference
// model checked every cycle on the falling edge, plus literal expectations.
module tb_axi_rd_arbiter;
    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy, timeout_err;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad   = 0;

    axi_rd_if m0_if ();
    axi_rd_if m1_if ();
    axi_rd_if axi_if ();

    axi_rd_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .io_AXI      (axi_if),
        .busy        (busy),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // Transaction view: idle, or one read owned by mdl_owner that is either
    // still presenting its address, waiting for data, or failed (error beat).
    bit          mdl_busy = 0, mdl_addr_done = 0, mdl_err = 0, mdl_sticky = 0;
    int          mdl_owner = 0, mdl_prev = 1, mdl_age = 0;
    logic [31:0] mdl_addr = '0;

    always @(negedge clk) begin
        logic        av[2], rr[2];
        logic [31:0] ad[2];
        logic        a_arr[2], a_rv[2], a_rs[2];
        logic [31:0] a_rd[2];
        logic        e_arr[2], e_rv[2], e_rs[2];
        logic [31:0] e_rd[2];
        logic        e_arv, e_rr, done;
        int          cand;

        av[0] = m0_if.araddr_valid;  av[1] = m1_if.araddr_valid;
        rr[0] = m0_if.raddr_ready;   rr[1] = m1_if.raddr_ready;
        ad[0] = m0_if.araddr_bits_addr; ad[1] = m1_if.araddr_bits_addr;
        a_arr[0] = m0_if.araddr_ready; a_arr[1] = m1_if.araddr_ready;
        a_rv[0]  = m0_if.raddr_valid;  a_rv[1]  = m1_if.raddr_valid;
        a_rd[0]  = m0_if.raddr_bits_data; a_rd[1] = m1_if.raddr_bits_data;
        a_rs[0]  = m0_if.raddr_bits_resp; a_rs[1] = m1_if.raddr_bits_resp;

        for (int i = 0; i < 2; i++) begin
            e_arr[i] = 0; e_rv[i] = 0; e_rs[i] = 0; e_rd[i] = '0;
        end
        e_arv = 0;
        e_rr  = 0;
        cand  = -1;

        if (!rst) begin
            mdl_busy = 0; mdl_prev = 1; mdl_sticky = 0;
        end else if (!mdl_busy) begin
            if (av[0] && av[1]) cand = (mdl_prev == 0) ? 1 : 0;
            else if (av[0])     cand = 0;
            else if (av[1])     cand = 1;
            if (cand >= 0) e_arr[cand] = 1;
        end else if (mdl_err) begin
            e_rv[mdl_owner] = 1;
            e_rs[mdl_owner] = 1;
            e_rr = 1;
        end else if (!mdl_addr_done) begin
            e_arv = 1;
        end else begin
            e_rv[mdl_owner] = axi_if.raddr_valid;
            if (axi_if.raddr_valid) begin
                e_rd[mdl_owner] = axi_if.raddr_bits_data;
                e_rs[mdl_owner] = axi_if.raddr_bits_resp;
            end
            e_rr = rr[mdl_owner];
        end

        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d_araddr_ready", i), 32'(a_arr[i]), 32'(e_arr[i]));
            chk($sformatf("m%0d_raddr_valid", i),  32'(a_rv[i]),  32'(e_rv[i]));
            chk($sformatf("m%0d_raddr_data", i),   a_rd[i],       e_rd[i]);
            chk($sformatf("m%0d_raddr_resp", i),   32'(a_rs[i]),  32'(e_rs[i]));
        end
        chk("io_araddr_valid", 32'(axi_if.araddr_valid), 32'(e_arv));
        if (e_arv) chk("io_araddr_addr", axi_if.araddr_bits_addr, mdl_addr);
        chk("io_raddr_ready", 32'(axi_if.raddr_ready), 32'(e_rr));
        chk("busy", 32'(busy), 32'(mdl_busy && rst));
        chk("timeout_err", 32'(timeout_err), 32'(mdl_sticky && rst));

        // Advance the model to what the next clock edge produces.
        if (rst) begin
            if (!mdl_busy) begin
                if (cand >= 0) begin
                    mdl_busy = 1; mdl_owner = cand; mdl_addr = ad[cand];
                    mdl_age = 0; mdl_addr_done = 0; mdl_err = 0;
                end
            end else if (mdl_err) begin
                if (rr[mdl_owner]) begin
                    mdl_busy = 0; mdl_prev = mdl_owner;
                end
            end else begin
                done = mdl_addr_done ? (axi_if.raddr_valid && rr[mdl_owner])
                                     : axi_if.araddr_ready;
                if (done) begin
                    if (mdl_addr_done) begin
                        mdl_busy = 0; mdl_prev = mdl_owner;
                    end else begin
                        mdl_addr_done = 1;
                    end
                end else if (mdl_age >= TMO - 1) begin
                    mdl_err = 1; mdl_sticky = 1;
                end
                mdl_age++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int deliveries;
    int exp_order[3] = '{0, 1, 0};

    initial begin
        m0_if.araddr_valid = 1; m0_if.araddr_bits_addr = 32'h8000_0000;
        m0_if.raddr_ready = 0;
        m1_if.araddr_valid = 0; m1_if.araddr_bits_addr = '0; m1_if.raddr_ready = 0;
        axi_if.araddr_ready = 0; axi_if.raddr_valid = 0;
        axi_if.raddr_bits_data = '0; axi_if.raddr_bits_resp = 0;

        // Reset: request pending but nothing offered.
        repeat (2) tick();
        @(negedge clk);
        chk("rst_m0_ready", 32'(m0_if.araddr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();

        // Simultaneous requests, three grants m0, m1, m0.
        rst = 1;
        m0_if.araddr_bits_addr = 32'h8000_0004;
        m1_if.araddr_valid = 1; m1_if.araddr_bits_addr = 32'h8000_1000;
        axi_if.araddr_ready = 1; axi_if.raddr_valid = 1;
        axi_if.raddr_bits_data = 32'h1111_2222;
        m0_if.raddr_ready = 1; m1_if.raddr_ready = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k),
                32'(exp_order[k] == 1 ? m1_if.araddr_ready : m0_if.araddr_ready), 32'd1);
            tick();
            @(negedge clk);
            chk($sformatf("rr_addr%0d", k), axi_if.araddr_bits_addr,
                exp_order[k] == 1 ? 32'h8000_1000 : 32'h8000_0004);
            tick();
            tick();
        end
        m0_if.araddr_valid = 0; m1_if.araddr_valid = 0; axi_if.raddr_valid = 0;
        tick();

        // Single IFU read.
        m0_if.araddr_valid = 1; m0_if.araddr_bits_addr = 32'h8000_0000;
        tick();
        m0_if.araddr_valid = 0;
        @(negedge clk);
        chk("t1_arvalid", 32'(axi_if.araddr_valid), 32'd1);
        chk("t1_addr", axi_if.araddr_bits_addr, 32'h8000_0000);
        tick();
        axi_if.raddr_valid = 1; axi_if.raddr_bits_data = 32'h0010_0073;
        @(negedge clk);
        chk("t1_m0_valid", 32'(m0_if.raddr_valid), 32'd1);
        chk("t1_m0_data", m0_if.raddr_bits_data, 32'h0010_0073);
        chk("t1_m0_resp", 32'(m0_if.raddr_bits_resp), 32'd0);
        chk("t1_m1_valid", 32'(m1_if.raddr_valid), 32'd0);
        tick();
        axi_if.raddr_valid = 0;
        @(negedge clk);
        chk("t1_busy_drop", 32'(busy), 32'd0);

        // Backpressure on both halves.
        m1_if.araddr_valid = 1; m1_if.araddr_bits_addr = 32'h8000_2000;
        m1_if.raddr_ready = 0; axi_if.araddr_ready = 0;
        tick();
        m1_if.araddr_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_arvalid_held", 32'(axi_if.araddr_valid), 32'd1);
            chk("t3_addr_stable", axi_if.araddr_bits_addr, 32'h8000_2000);
            tick();
        end
        axi_if.araddr_ready = 1;
        tick();
        axi_if.araddr_ready = 0;
        axi_if.raddr_valid = 1; axi_if.raddr_bits_data = 32'hDEAD_BEEF;
        deliveries = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_slave_ready_low", 32'(axi_if.raddr_ready), 32'd0);
            chk("t3_m1_data_held", m1_if.raddr_bits_data, 32'hDEAD_BEEF);
            if (m1_if.raddr_valid && m1_if.raddr_ready) deliveries++;
            tick();
        end
        m1_if.raddr_ready = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (m1_if.raddr_valid && m1_if.raddr_ready &&
                m1_if.raddr_bits_data == 32'hDEAD_BEEF) deliveries++;
            tick();
        end
        chk("t3_delivered_once", 32'(deliveries), 32'd1);
        axi_if.raddr_valid = 0;
        tick();

        // Expiry race: data handshake on the last allowed cycle.
        m0_if.araddr_valid = 1; m0_if.araddr_bits_addr = 32'h8000_0040;
        axi_if.araddr_ready = 0; m0_if.raddr_ready = 0;
        tick();
        m0_if.araddr_valid = 0;
        repeat (3) tick();
        axi_if.araddr_ready = 1;
        tick();
        axi_if.araddr_ready = 0;
        repeat (11) tick();
        axi_if.raddr_valid = 1; axi_if.raddr_bits_data = 32'h5A5A_0015;
        m0_if.raddr_ready = 1;
        @(negedge clk);
        chk("t5_m0_data", m0_if.raddr_bits_data, 32'h5A5A_0015);
        chk("t5_m0_resp", 32'(m0_if.raddr_bits_resp), 32'd0);
        tick();
        axi_if.raddr_valid = 0;
        @(negedge clk);
        chk("t5_idle", 32'(dbg_state), 32'd0);
        chk("t5_no_timeout", 32'(timeout_err), 32'd0);

        // Timeout: slave never answers.
        m1_if.araddr_valid = 1; m1_if.araddr_bits_addr = 32'h8000_3000;
        m1_if.raddr_ready = 0;
        tick();
        m1_if.araddr_valid = 0;
        repeat (15) tick();
        @(negedge clk);
        chk("t4_cycle16_addr", 32'(dbg_state), 32'd1);
        chk("t4_cycle16_flag", 32'(timeout_err), 32'd0);
        tick();
        axi_if.raddr_valid = 1; axi_if.raddr_bits_data = 32'h0000_0BAD;
        @(negedge clk);
        chk("t4_err_state", 32'(dbg_state), 32'd3);
        chk("t4_m1_valid", 32'(m1_if.raddr_valid), 32'd1);
        chk("t4_m1_data", m1_if.raddr_bits_data, 32'd0);
        chk("t4_m1_resp", 32'(m1_if.raddr_bits_resp), 32'd1);
        chk("t4_flag", 32'(timeout_err), 32'd1);
        tick();
        tick();
        m1_if.raddr_ready = 1;
        tick();
        axi_if.raddr_valid = 0;
        m1_if.araddr_valid = 1; m1_if.araddr_bits_addr = 32'h8000_3004;
        axi_if.araddr_ready = 1;
        tick();
        m1_if.araddr_valid = 0;
        axi_if.raddr_valid = 1; axi_if.raddr_bits_data = 32'h0000_CAFE;
        tick();
        @(negedge clk);
        chk("t4_next_data", m1_if.raddr_bits_data, 32'h0000_CAFE);
        chk("t4_next_resp", 32'(m1_if.raddr_bits_resp), 32'd0);
        chk("t4_flag_sticky", 32'(timeout_err), 32'd1);
        tick();
        axi_if.raddr_valid = 0;
        tick();

        // Async reset while in DATA.
        m1_if.araddr_valid = 1; m1_if.araddr_bits_addr = 32'h8000_4000;
        m1_if.raddr_ready = 0;
        tick();
        m1_if.araddr_valid = 0;
        tick();
        axi_if.raddr_valid = 1; axi_if.raddr_bits_data = 32'h0000_0077;
        #2 rst = 0;
        #1;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_m1_valid", 32'(m1_if.raddr_valid), 32'd0);
        chk("t6_m1_data", m1_if.raddr_bits_data, 32'd0);
        chk("t6_io_rready", 32'(axi_if.raddr_ready), 32'd0);
        chk("t6_flag_clr", 32'(timeout_err), 32'd0);
        tick();
        rst = 1;
        axi_if.raddr_valid = 0;
        m0_if.araddr_valid = 1; m0_if.araddr_bits_addr = 32'h8000_5000;
        m1_if.araddr_valid = 1; m1_if.araddr_bits_addr = 32'h8000_6000;
        m0_if.raddr_ready = 1; m1_if.raddr_ready = 1;
        axi_if.raddr_bits_data = 32'h0000_0099;
        @(negedge clk);
        chk("t6_m0_first", 32'(m0_if.araddr_ready), 32'd1);
        chk("t6_m1_waits", 32'(m1_if.araddr_ready), 32'd0);
        tick();
        m0_if.araddr_valid = 0;
        axi_if.raddr_valid = 1;
        repeat (3) tick();
        m1_if.araddr_valid = 0;
        repeat (3) tick();
        axi_if.raddr_valid = 0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
